led_row_scanner: RTL

LED_ROW_SCANNER -- requirements
Module: led_row_scanner

---
 rtl/led_matrix_pkg.sv | 22 ++
 rtl/row_decoder.sv | 18 +
 rtl/led_row_scanner.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// Shared scan-state enumeration and default geometry for the LED matrix scanner.
// The BLANK state exists only when SCAN_GHOST_BLANK_EN is defined.
package led_matrix_pkg;

   localparam int DEF_ROWS  = 8;
   localparam int DEF_COLS  = 8;
   localparam int DEF_DWELL = 2;

`ifdef SCAN_GHOST_BLANK_EN
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_t;
`else
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      SHOW  = 2'd2
   } scan_state_t;
`endif

endpackage

// File: rtl/row_decoder.sv
// Binary row address to one-hot, active-high row drive; all zeros when en_i is low.
module row_decoder #(
   parameter int ROWS = 8,
   parameter int AW   = 3
) (
   input  logic [AW-1:0]   addr_i,
   input  logic            en_i,
   output logic [ROWS-1:0] sel_o
);

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_sel
         assign sel_o[gi] = en_i && (addr_i == AW'(gi));
      end
   endgenerate

endmodule

// File: rtl/led_row_scanner.sv
// Multiplexed LED row scanner: fetch a row from the frame store, show it for DWELL ticks.
// Define SCAN_GHOST_BLANK_EN to insert a one-tick BLANK between fetch and show.
module led_row_scanner
   import led_matrix_pkg::*;
#(
   parameter int ROWS  = DEF_ROWS,
   parameter int COLS  = DEF_COLS,
   parameter int DWELL = DEF_DWELL
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tickIn,
   input  logic                    scanEn,
   output logic                    rowReq,
   output logic [$clog2(ROWS)-1:0] rowAddr,
   input  logic [COLS-1:0]         rowData,
   input  logic                    rowValid,
   output logic [ROWS-1:0]         rowSel,
   output logic [COLS-1:0]         colOut,
   output logic                    frameDone
);

   localparam int              AW         = $clog2(ROWS);
   localparam logic [AW-1:0]   LAST_ROW   = AW'(ROWS - 1);
   localparam logic [3:0]      DWELL_LAST = 4'(DWELL - 1);

   scan_state_t     state_q;
   logic [AW-1:0]   addr_q;
   logic            req_q;
   logic [ROWS-1:0] sel_q;
   logic [COLS-1:0] colout_q;
   logic            done_q;
   logic [3:0]      dwell_q;
   logic            enter_show;
   logic [ROWS-1:0] sel_d;

`ifdef SCAN_GHOST_BLANK_EN
   // Fetched data waits here while the rows are dark.
   logic [COLS-1:0] col_q;
   assign enter_show = (state_q == BLANK) && tickIn;
`else
   assign enter_show = (state_q == FETCH) && rowValid;
`endif

   row_decoder #(
      .ROWS (ROWS),
      .AW   (AW)
   ) u_row_decoder (
      .addr_i (addr_q),
      .en_i   (enter_show),
      .sel_o  (sel_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FETCH;
         addr_q   <= '0;
         req_q    <= 1'b0;
         sel_q    <= '0;
         colout_q <= '0;
         done_q   <= 1'b0;
         dwell_q  <= '0;
`ifdef SCAN_GHOST_BLANK_EN
         col_q    <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (!scanEn) begin
            state_q  <= FETCH;
            addr_q   <= '0;
            req_q    <= 1'b0;
            sel_q    <= '0;
            colout_q <= '0;
            dwell_q  <= '0;
         end else begin
            case (state_q)
               FETCH: begin
                  if (rowValid) begin
                     req_q <= 1'b0;
`ifdef SCAN_GHOST_BLANK_EN
                     col_q   <= rowData;
                     state_q <= BLANK;
`else
                     colout_q <= rowData;
                     sel_q    <= sel_d;
                     dwell_q  <= '0;
                     state_q  <= SHOW;
`endif
                  end else begin
                     req_q <= 1'b1;
                  end
               end
`ifdef SCAN_GHOST_BLANK_EN
               BLANK: begin
                  if (tickIn) begin
                     colout_q <= col_q;
                     sel_q    <= sel_d;
                     dwell_q  <= '0;
                     state_q  <= SHOW;
                  end
               end
`endif
               SHOW: begin
                  if (tickIn) begin
                     if (dwell_q == DWELL_LAST) begin
                        state_q  <= FETCH;
                        req_q    <= 1'b1;
                        sel_q    <= '0;
                        colout_q <= '0;
                        dwell_q  <= '0;
                        if (addr_q == LAST_ROW) begin
                           addr_q <= '0;
                           done_q <= 1'b1;
                        end else begin
                           addr_q <= addr_q + AW'(1);
                        end
                     end else begin
                        dwell_q <= dwell_q + 4'd1;
                     end
                  end
               end
               default: begin
                  state_q  <= FETCH;
                  req_q    <= 1'b0;
                  sel_q    <= '0;
                  colout_q <= '0;
                  dwell_q  <= '0;
               end
            endcase
         end
      end
   end

   assign rowReq    = req_q;
   assign rowAddr   = addr_q;
   assign rowSel    = sel_q;
   assign colOut    = colout_q;
   assign frameDone = done_q;

endmodule
